// File: rtl/fsram_read_ctrl.sv
// Frame-scan read controller for the feature-map SRAMs.
// Issues kernel-row reads and a Data_process code stream aligned to SRAM data.
module fsram_read_ctrl #(
  parameter int H_IMG  = 16,
  parameter int W_IMG  = 16,
  parameter int ADDR_W = 10
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       start,
  input  logic                       sram_sel,
  output logic                       rd_en_1,
  output logic                       rd_en_2,
  output logic [ADDR_W-1:0]          rd_addr,
  output logic [2:0]                 data_process,
  output logic                       FSRAM1,
  output logic                       FSRAM2,
  output logic [$clog2(H_IMG)-1:0]   out_row,
  output logic                       busy,
  output logic                       done
);

  localparam int N  = W_IMG / 2;
  localparam int RW = $clog2(H_IMG);
  localparam int CW = $clog2(2 * N);

  localparam logic [1:0] S_IDLE  = 2'd0;
  localparam logic [1:0] S_RUN   = 2'd1;
  localparam logic [1:0] S_DRAIN = 2'd2;
  localparam logic [1:0] S_FIN   = 2'd3;

  localparam logic [2:0] DP_IDLE  = 3'd0;
  localparam logic [2:0] DP_PAD   = 3'd1;
  localparam logic [2:0] DP_HEAD  = 3'd2;
  localparam logic [2:0] DP_TAIL  = 3'd4;
  localparam logic [2:0] DP_FRONT = 3'd5;
  localparam logic [2:0] DP_BACK  = 3'd6;

  localparam logic [CW-1:0] C_LAST = CW'(2 * N - 1);
  localparam logic [RW-1:0] R_LAST = RW'(H_IMG - 1);

  logic [1:0]        state_q;
  logic [RW-1:0]     row_q;
  logic [1:0]        slot_q;
  logic [CW-1:0]     cyc_q;
  logic              dcnt_q;
  logic              sel_q;
  logic [ADDR_W-1:0] addr_q;

  logic [2:0]        s1_code;
  logic              s1_f1;
  logic              s1_f2;
  logic [RW-1:0]     s1_row;

  logic              run;
  logic              pad;
  logic              slot_end;
  logic              frame_end;
  logic              iss_rd;
  logic [2:0]        iss_code;
  logic [ADDR_W-1:0] iss_addr;
  logic [31:0]       krow;
  logic [31:0]       word;

  always_comb begin
    run       = state_q == S_RUN;
    slot_end  = cyc_q == C_LAST;
    frame_end = slot_end && slot_q == 2'd2 && row_q == R_LAST;
    pad       = (row_q == '0 && slot_q == 2'd0) ||
                (row_q == R_LAST && slot_q == 2'd2);
    krow      = 32'(row_q) + 32'(slot_q) - 32'd1;
    // cycle 0 reads word 0, then each word w is read twice at cycles 2w-1, 2w
    word      = (32'(cyc_q) + 32'd1) >> 1;
    iss_addr  = ADDR_W'(krow * 32'(N) + word);
    iss_rd    = 1'b0;
    iss_code  = DP_IDLE;
    if (run) begin
      unique case (1'b1)
        pad:
          iss_code = (cyc_q == '0) ? DP_PAD : DP_TAIL;
        !pad && slot_end:
          iss_code = DP_TAIL;
        default: begin
          iss_rd   = 1'b1;
          iss_code = (cyc_q == '0) ? DP_HEAD :
                     cyc_q[0]      ? DP_FRONT : DP_BACK;
        end
      endcase
    end
  end

  assign rd_en_1 = iss_rd & ~sel_q;
  assign rd_en_2 = iss_rd & sel_q;
  assign rd_addr = iss_rd ? iss_addr : addr_q;
  assign busy    = state_q != S_IDLE;
  assign done    = state_q == S_FIN;

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= S_IDLE;
      row_q   <= '0;
      slot_q  <= '0;
      cyc_q   <= '0;
      dcnt_q  <= 1'b0;
      sel_q   <= 1'b0;
    end else begin
      unique case (state_q)
        S_IDLE: begin
          if (start) begin
            state_q <= S_RUN;
            sel_q   <= sram_sel;
            row_q   <= '0;
            slot_q  <= '0;
            cyc_q   <= '0;
          end
        end
        S_RUN: begin
          if (frame_end) begin
            state_q <= S_DRAIN;
            dcnt_q  <= 1'b0;
          end
          if (slot_end) begin
            cyc_q <= '0;
            if (slot_q == 2'd2) begin
              slot_q <= '0;
              row_q  <= row_q + 1'b1;
            end else begin
              slot_q <= slot_q + 1'b1;
            end
          end else begin
            cyc_q <= cyc_q + 1'b1;
          end
        end
        S_DRAIN: begin
          dcnt_q <= ~dcnt_q;
          if (dcnt_q) state_q <= S_FIN;
        end
        default: state_q <= S_IDLE;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      addr_q <= '0;
    end else if (iss_rd) begin
      addr_q <= iss_addr;
    end
  end

  // two-stage delay: SRAM read latency, then the Data_process input register
  always_ff @(posedge clk) begin
    if (rst) begin
      s1_code      <= DP_IDLE;
      s1_f1        <= 1'b0;
      s1_f2        <= 1'b0;
      s1_row       <= '0;
      data_process <= DP_IDLE;
      FSRAM1       <= 1'b0;
      FSRAM2       <= 1'b0;
      out_row      <= '0;
    end else begin
      s1_code      <= iss_code;
      s1_f1        <= run & ~sel_q;
      s1_f2        <= run & sel_q;
      s1_row       <= run ? row_q : '0;
      data_process <= s1_code;
      FSRAM1       <= s1_f1;
      FSRAM2       <= s1_f2;
      out_row      <= s1_row;
    end
  end

endmodule
